hazard_stall_unit: RTL and testbench
====================================

# hazard_stall_unit

Parametrised pipeline hazard and stall controller for the five-stage MIPS core. It sits beside the IF/ID and ID/EX pipeline registers and drives the same three controls as the single-cycle load-use detector: PC write enable, IF/ID write enable and the control-bubble mux select. It adds four capabilities:
- configurable multi-cycle load-use stalls;
- branch-resolved-in-ID hazards;
- a multiply/divide busy interlock;
- IF/ID flush cancellation and a saturating stall-cycle counter.

## Interface
Parameters:
- REG_AW, 5: register address width.
- LOAD_STALL, 1: bubbles required between a load in EX and a dependent consumer; legal range 1..7.
- MD_LAT, 4: multiply/divide occupancy in cycles; legal range 1..63.
- BRANCH_IN_ID, 1: when 1, branch operand hazards against EX are detected; when 0, branch checks are disabled.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_ex_mem_read  in  1  instruction in EX is a load.
- id_ex_reg_write  in  1  instruction in EX writes a register.
- id_ex_dst  in  REG_AW  destination register of the EX instruction (rt for loads).
- if_id_rs, if_id_rt  in  REG_AW  source registers of the ID instruction.
- if_id_use_rs, if_id_use_rt  in  1  the ID instruction actually reads rs / rt.
- if_id_is_branch  in  1  ID instruction is a branch that compares in ID.
- if_id_is_md  in  1  ID instruction is mult/multu/div/divu.
- if_id_rd_hilo  in  1  ID instruction is mfhi/mflo.
- if_id_flush  in  1  ID instruction is squashed this cycle.
- pc_write  out  1  1 means the PC updates.
- if_id_write  out  1  1 means IF/ID loads.
- mux_ctrl  out  1  1 means ID control passes to ID/EX; 0 means a zero-control bubble is inserted.
- md_busy  out  1  multiply/divide unit is occupied.
- stall_cycles  out  16  count of cycles with stall asserted; saturates at 16'hFFFF.

## Operation
- **Stall signal.** stall = load_hz | lstall_st | md_hz.
  - pc_write = if_id_write = mux_ctrl = ~stall.
  - All three are combinational from state and inputs.
- **Source match.** match_s is true for a source s when use_s is set, s equals id_ex_dst, and id_ex_dst is not 0. Register 0 never creates a hazard.
- **load_hz.** Asserted when:
  - the ID instruction is not flushed and any match exists, and
  - either id_ex_mem_read is set, or BRANCH_IN_ID is set with if_id_is_branch and id_ex_reg_write set (ALU result needed in ID).
- **Stall length**, counted from the detection cycle:
  - load vs non-branch consumer: LOAD_STALL cycles;
  - load vs branch consumer: LOAD_STALL+1 cycles;
  - ALU vs branch consumer: 1 cycle.
- **FSM.**
  - States: IDLE and LSTALL. Counter cnt is 3 bits.
  - IDLE: if load_hz is set and the required length N is greater than 1, go to LSTALL with cnt = N-1. Otherwise stay in IDLE.
  - LSTALL: lstall_st = 1. At each edge, if cnt == 1 go to IDLE, else decrement cnt.
  - The hazard inputs are not re-evaluated while in LSTALL, because ID/EX holds a bubble.
- **Flush.** if_id_flush = 1 masks load_hz and md_hz in that cycle. If the FSM is in LSTALL, it returns to IDLE at the next edge and lstall_st drops in the flush cycle itself.
- **Multiply/divide interlock.**
  - md_cnt is 6 bits; md_busy = (md_cnt != 0).
  - md_hz = md_busy & (if_id_is_md | if_id_rd_hilo) & ~if_id_flush.
  - Issue happens on a cycle where if_id_is_md = 1 and stall = 0. At that edge, md_cnt loads MD_LAT.
  - Otherwise md_cnt decrements while non-zero.
  - The md logic runs independently of the FSM; overlapping hazards OR together.
- **Stall counter.** stall_cycles increments at each edge where stall = 1, and holds at 16'hFFFF.

## Timing
- **Reset.** Sampled on the clock edge while rst_n = 0:
  - FSM goes to IDLE; cnt, md_cnt and stall_cycles are cleared.
  - While rst_n is 0, pc_write, if_id_write and mux_ctrl are forced to 1 and md_busy to 0 regardless of inputs.
  - Reset in the middle of LSTALL or an md operation aborts it; the first cycle after release is stall-free unless a new hazard is present.
- **Detection.** Zero-latency: stall drops pc_write and the other controls in the same cycle the hazard inputs appear.
- **Stall release.** stall deasserts on the cycle after the last counted stall cycle.
- **md issue.** md_busy rises the cycle after issue and stays high for exactly MD_LAT cycles.
- **Simultaneous events.** If a load hazard and md_hz occur together, stall lasts max(load length, remaining md_cnt). An md instruction held by a load stall does not issue until stall = 0.

## Test plan
- **Load-use, rs:** LOAD_STALL=1, id_ex_mem_read=1, id_ex_dst=8, if_id_rs=8 with use -> exactly 1 cycle with pc_write=if_id_write=mux_ctrl=0; stall_cycles = 1.
- **Register 0 and unused source:** id_ex_dst=0 matching rs -> no stall. Also use_rt=0 with an rt match -> no stall.
- **Multi-cycle load, branch:** LOAD_STALL=3, load dst=5, branch reading rs=5 -> 4 consecutive stall cycles, then IDLE. With BRANCH_IN_ID=0 -> 3 cycles.
- **Flush mid-stall:** LOAD_STALL=3, assert if_id_flush on the 2nd stall cycle -> stall low in that cycle; FSM in IDLE next cycle.
- **Multiply/divide:** MD_LAT=4, issue mult, then mflo in ID -> md_busy high for 4 cycles; mflo stalled until md_cnt = 0; no stall on a following add.
- **Reset and saturation:** rst_n=0 during LSTALL -> outputs 1/1/1/0 and counter 0. Force 65540 stall cycles -> stall_cycles = 16'hFFFF.

Source files
------------

// File: rtl/hazard_stall_unit_if.sv
// hazard_stall_unit_if: EX/ID hazard inputs and pipeline-control outputs of the stall unit.
interface hazard_stall_unit_if #(parameter int REG_AW = 5);
  logic              id_ex_mem_read, id_ex_reg_write;
  logic [REG_AW-1:0] id_ex_dst, if_id_rs, if_id_rt;
  logic              if_id_use_rs, if_id_use_rt, if_id_is_branch, if_id_is_md, if_id_rd_hilo, if_id_flush;
  logic              pc_write, if_id_write, mux_ctrl, md_busy;
  logic [15:0]       stall_cycles;
  modport master (
    output id_ex_mem_read, id_ex_reg_write, id_ex_dst, if_id_rs, if_id_rt,
           if_id_use_rs, if_id_use_rt, if_id_is_branch, if_id_is_md, if_id_rd_hilo, if_id_flush,
    input  pc_write, if_id_write, mux_ctrl, md_busy, stall_cycles
  );
  modport slave (
    input  id_ex_mem_read, id_ex_reg_write, id_ex_dst, if_id_rs, if_id_rt,
           if_id_use_rs, if_id_use_rt, if_id_is_branch, if_id_is_md, if_id_rd_hilo, if_id_flush,
    output pc_write, if_id_write, mux_ctrl, md_busy, stall_cycles
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use / branch-in-ID / mul-div interlock stall controller with
// flush cancellation and a saturating stall-cycle counter.
module hazard_stall_unit #(
  parameter int REG_AW       = 5,
  parameter int LOAD_STALL   = 1,
  parameter int MD_LAT       = 4,
  parameter int BRANCH_IN_ID = 1
) (
  input logic             clk,
  input logic             rst_n,
  hazard_stall_unit_if.slave hz
);
  typedef enum logic {IDLE, LSTALL} state_t;
  state_t      state, stateNext;
  logic [2:0]  cnt, cntNext;
  logic [5:0]  mdCnt;
  logic [15:0] stallCnt;
  logic [3:0]  loadLen;
  logic        matchRs, matchRt, isBranch, loadHz, lstallSt, mdBusy, mdHz, stall;
  assign matchRs  = hz.if_id_use_rs && hz.if_id_rs == hz.id_ex_dst && hz.id_ex_dst != '0;
  assign matchRt  = hz.if_id_use_rt && hz.if_id_rt == hz.id_ex_dst && hz.id_ex_dst != '0;
  assign isBranch = BRANCH_IN_ID != 0 && hz.if_id_is_branch;
  assign loadHz   = !hz.if_id_flush && (matchRs || matchRt) &&
                    (hz.id_ex_mem_read || (isBranch && hz.id_ex_reg_write));
  // a branch comparing in ID needs one extra bubble after a load; an ALU producer needs one
  assign loadLen  = !hz.id_ex_mem_read ? 4'd1 : isBranch ? 4'(LOAD_STALL + 1) : 4'(LOAD_STALL);
  assign lstallSt = state == LSTALL && !hz.if_id_flush;
  assign mdBusy   = mdCnt != '0;
  assign mdHz     = mdBusy && (hz.if_id_is_md || hz.if_id_rd_hilo) && !hz.if_id_flush;
  assign stall    = loadHz || lstallSt || mdHz;
  // controls are forced to their pass-through values while reset is held
  assign hz.pc_write     = !rst_n || !stall;
  assign hz.if_id_write  = !rst_n || !stall;
  assign hz.mux_ctrl     = !rst_n || !stall;
  assign hz.md_busy      = rst_n && mdBusy;
  assign hz.stall_cycles = stallCnt;
  always_comb begin
    stateNext = state == IDLE ? (loadHz && loadLen > 4'd1 ? LSTALL : IDLE)
                              : (hz.if_id_flush || cnt == 3'd1 ? IDLE : LSTALL);
    cntNext   = state == IDLE ? 3'(loadLen - 4'd1) : cnt - 3'd1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mdCnt    <= '0;
      stallCnt <= '0;
    end else begin
      mdCnt    <= hz.if_id_is_md && !stall ? 6'(MD_LAT) : mdCnt - 6'(mdBusy);
      stallCnt <= stallCnt + 16'(stall && stallCnt != 16'hFFFF);
    end
  end
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: two configurations (A: LOAD_STALL=3, branch-in-ID; B: LOAD_STALL=1, no
// branch checks) driven with identical vectors and checked against hand-derived expectations.
module tb_hazard_stall_unit;
  typedef struct {
    logic       rn, mr, rw;
    logic [4:0] dst, rs, rt;
    logic       urs, urt, br, md, hilo, fl;
    logic       sa, ba, sb, bb;
  } vec_t;
  typedef struct {logic sa, ba, sb, bb;} exp_t;

  logic clk = 0, rstN;
  int   nCmp = 0, nBad = 0;
  vec_t tv[$];
  exp_t sbq[$];

  always #5 clk = ~clk;

  hazard_stall_unit_if #(.REG_AW(5)) ifA(), ifB();
  assign {ifB.id_ex_mem_read, ifB.id_ex_reg_write, ifB.id_ex_dst, ifB.if_id_rs, ifB.if_id_rt,
          ifB.if_id_use_rs, ifB.if_id_use_rt, ifB.if_id_is_branch, ifB.if_id_is_md,
          ifB.if_id_rd_hilo, ifB.if_id_flush} =
         {ifA.id_ex_mem_read, ifA.id_ex_reg_write, ifA.id_ex_dst, ifA.if_id_rs, ifA.if_id_rt,
          ifA.if_id_use_rs, ifA.if_id_use_rt, ifA.if_id_is_branch, ifA.if_id_is_md,
          ifA.if_id_rd_hilo, ifA.if_id_flush};

  hazard_stall_unit #(.REG_AW(5), .LOAD_STALL(3), .MD_LAT(4), .BRANCH_IN_ID(1))
    dutA (.clk(clk), .rst_n(rstN), .hz(ifA.slave));
  hazard_stall_unit #(.REG_AW(5), .LOAD_STALL(1), .MD_LAT(4), .BRANCH_IN_ID(0))
    dutB (.clk(clk), .rst_n(rstN), .hz(ifB.slave));

  function automatic vec_t mk(logic rn, mr, rw, logic [4:0] dst, rs, rt,
                              logic urs, urt, br, md, hilo, fl, sa, ba, sb, bb);
    vec_t v;
    v.rn = rn; v.mr = mr; v.rw = rw; v.dst = dst; v.rs = rs; v.rt = rt;
    v.urs = urs; v.urt = urt; v.br = br; v.md = md; v.hilo = hilo; v.fl = fl;
    v.sa = sa; v.ba = ba; v.sb = sb; v.bb = bb;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rstN = v.rn;
    ifA.id_ex_mem_read = v.mr; ifA.id_ex_reg_write = v.rw; ifA.id_ex_dst = v.dst;
    ifA.if_id_rs = v.rs; ifA.if_id_rt = v.rt; ifA.if_id_use_rs = v.urs; ifA.if_id_use_rt = v.urt;
    ifA.if_id_is_branch = v.br; ifA.if_id_is_md = v.md; ifA.if_id_rd_hilo = v.hilo;
    ifA.if_id_flush = v.fl;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    // rn mr rw dst rs rt urs urt br md hilo fl | stA busyA stB busyB
    tv.push_back(mk(0,1,1,8,8,0,1,0,0,0,0,0, 0,0,0,0)); // reset masks a live hazard
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    tv.push_back(mk(1,1,1,8,8,0,1,0,0,0,0,0, 1,0,1,0)); // load-use rs
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    tv.push_back(mk(1,1,1,0,0,0,1,0,0,0,0,0, 0,0,0,0)); // register 0
    tv.push_back(mk(1,1,1,9,3,9,1,0,0,0,0,0, 0,0,0,0)); // rt match but unused
    tv.push_back(mk(1,1,1,9,3,9,1,1,0,0,0,0, 1,0,1,0)); // rt match used
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    tv.push_back(mk(1,1,1,5,5,0,1,0,1,0,0,0, 1,0,1,0)); // load vs branch
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    tv.push_back(mk(1,0,1,6,6,0,1,0,1,0,0,0, 1,0,0,0)); // ALU vs branch
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    tv.push_back(mk(1,0,1,6,6,0,1,0,0,0,0,0, 0,0,0,0)); // ALU vs non-branch
    tv.push_back(mk(1,1,1,7,0,7,0,1,0,0,0,0, 1,0,1,0)); // load, then flush mid-stall
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    tv.push_back(mk(1,1,1,7,0,7,0,1,0,0,0,1, 0,0,0,0)); // flush masks detection
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,1,0,0, 0,0,0,0)); // mult issues
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,0, 1,1,1,1)); // mflo waits
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,0, 1,1,1,1));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,0, 1,1,1,1));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,0, 1,1,1,1));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,0, 0,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0)); // following add
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,1,0,0, 0,0,0,0)); // mult issues
    tv.push_back(mk(1,1,1,8,8,0,1,0,0,0,1,0, 1,1,1,1)); // load hazard overlaps md
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,0, 1,1,1,1));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,0, 1,1,1,1));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,0, 1,1,1,1));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,1,0, 0,0,0,0));
    tv.push_back(mk(1,1,1,8,8,0,1,0,0,1,0,0, 1,0,1,0)); // mult held by load stall
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,1,0,0, 1,0,0,0));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,1,0,0, 1,0,1,1));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,1,0,0, 0,0,1,1));
    tv.push_back(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,1,0,1));

    drive(tv[1]);
    tick();
    foreach (tv[i]) begin
      drive(tv[i]);
      e.sa = tv[i].sa; e.ba = tv[i].ba; e.sb = tv[i].sb; e.bb = tv[i].bb;
      sbq.push_back(e);
      @(negedge clk);
      e = sbq.pop_front();
      chk($sformatf("v%0d ctrlA", i), {29'd0, ifA.pc_write, ifA.if_id_write, ifA.mux_ctrl}, {29'd0, {3{~e.sa}}});
      chk($sformatf("v%0d busyA", i), {31'd0, ifA.md_busy}, {31'd0, e.ba});
      chk($sformatf("v%0d ctrlB", i), {29'd0, ifB.pc_write, ifB.if_id_write, ifB.mux_ctrl}, {29'd0, {3{~e.sb}}});
      chk($sformatf("v%0d busyB", i), {31'd0, ifB.md_busy}, {31'd0, e.bb});
      tick();
    end
    chk("cyclesA", {16'd0, ifA.stall_cycles}, 32'd23);
    chk("cyclesB", {16'd0, ifB.stall_cycles}, 32'd15);

    // reset while A is in LSTALL with the md unit still busy
    drive(mk(1,1,1,8,8,0,1,0,0,0,0,0, 0,0,0,0));
    tick();
    drive(mk(0,1,1,8,8,0,1,0,0,0,0,0, 0,0,0,0));
    @(negedge clk);
    chk("rstCtrlA", {29'd0, ifA.pc_write, ifA.if_id_write, ifA.mux_ctrl}, 32'd7);
    chk("rstBusyA", {31'd0, ifA.md_busy}, 32'd0);
    chk("rstCtrlB", {29'd0, ifB.pc_write, ifB.if_id_write, ifB.mux_ctrl}, 32'd7);
    tick();
    drive(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0));
    @(negedge clk);
    chk("postRstCtrlA", {29'd0, ifA.pc_write, ifA.if_id_write, ifA.mux_ctrl}, 32'd7);
    chk("postRstBusyA", {31'd0, ifA.md_busy}, 32'd0);
    chk("postRstCyclesA", {16'd0, ifA.stall_cycles}, 32'd0);
    chk("postRstCyclesB", {16'd0, ifB.stall_cycles}, 32'd0);
    tick();

    // hold a load hazard long enough to saturate both counters
    drive(mk(1,1,1,8,8,0,1,0,0,0,0,0, 0,0,0,0));
    repeat (65540) @(posedge clk);
    #1;
    chk("satA", {16'd0, ifA.stall_cycles}, 32'hFFFF);
    chk("satB", {16'd0, ifB.stall_cycles}, 32'hFFFF);
    chk("satCtrlB", {29'd0, ifB.pc_write, ifB.if_id_write, ifB.mux_ctrl}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
